// File: rtl/calc_pkg.sv
// Shared definitions for the calculator accumulator stage.
//   DEFAULT_WIDTH : datapath width, must match the adder/subtractor stage
//   OP_*          : command opcodes carried on IN_OP
//   ST_*          : sequencing FSM state encoding
package calc_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_WB    = 2'b10;

endpackage

// File: rtl/calc_ovf_detect.sv
// Two's-complement overflow detector for the adder/subtractor stage.
//   sign_a_i  : sign bit of operand A
//   sign_b_i  : sign bit of operand B
//   sign_r_i  : sign bit of the stage result
//   sub_sel_i : 1 when the stage computes A-B
//   ovf_o     : signed overflow of the operation
module calc_ovf_detect (
  input  logic sign_a_i,
  input  logic sign_b_i,
  input  logic sign_r_i,
  input  logic sub_sel_i,
  output logic ovf_o
);

  logic sign_b_eff;

  // Subtraction adds -B, so the effective B sign is inverted.
  assign sign_b_eff = sign_b_i ^ sub_sel_i;
  assign ovf_o      = (sign_a_i == sign_b_eff) && (sign_r_i != sign_a_i);

endmodule

// File: rtl/calc_acc_ctrl.sv
// Sequencing and accumulator stage around an external combinational
// adder/subtractor. Each accepted command presents A/B/SUB_SEL to the stage,
// waits one cycle for it to settle, then writes the result back.
//   CLK, RESET           : clock, async active-high reset
//   IN_VALID/IN_READY    : command handshake
//   IN_OP, IN_DATA       : opcode and operand
//   A_DATA, B_DATA       : registered operands to the adder/subtractor
//   SUB_SEL              : subtract-select to the adder/subtractor
//   ALU_RESULT           : adder/subtractor result
//   ACC                  : accumulator
//   OUT_VALID            : one-cycle pulse after each writeback
//   OVF, OVF_STICKY      : last-command overflow and accumulated overflow
module calc_acc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       IN_OP,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] A_DATA,
  output logic [WIDTH-1:0] B_DATA,
  output logic             SUB_SEL,
  input  logic [WIDTH-1:0] ALU_RESULT,
  output logic [WIDTH-1:0] ACC,
  output logic             OUT_VALID,
  output logic             OVF,
  output logic             OVF_STICKY
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_raw;
  logic             accept;

  calc_ovf_detect u_ovf_detect (
    .sign_a_i  (a_q[WIDTH-1]),
    .sign_b_i  (b_q[WIDTH-1]),
    .sign_r_i  (ALU_RESULT[WIDTH-1]),
    .sub_sel_i (sub_q),
    .ovf_o     (ovf_raw)
  );

  assign accept = (state_q == ST_IDLE) && IN_VALID;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (IN_VALID) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand capture: B_DATA doubles as the latched operand used by LOAD.
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    sub_d = sub_q;
    if (accept) begin
      op_d  = IN_OP;
      a_d   = acc_q;
      b_d   = IN_DATA;
      sub_d = (IN_OP == OP_SUB);
    end
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    sticky_d    = sticky_q;
    out_valid_d = (state_q == ST_WB);
    if (state_q == ST_WB) begin
      unique case (op_q)
        OP_LOAD: begin
          acc_d = b_q;
          ovf_d = 1'b0;
        end
        OP_ADD, OP_SUB: begin
          acc_d    = ALU_RESULT;
          ovf_d    = ovf_raw;
          sticky_d = sticky_q | ovf_raw;
        end
        OP_CLEAR: begin
          acc_d    = '0;
          ovf_d    = 1'b0;
          sticky_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY   = (state_q == ST_IDLE);
  assign A_DATA     = a_q;
  assign B_DATA     = b_q;
  assign SUB_SEL    = sub_q;
  assign ACC        = acc_q;
  assign OUT_VALID  = out_valid_q;
  assign OVF        = ovf_q;
  assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_calc_acc_ctrl.sv
// Directed bench for calc_acc_ctrl with a behavioural adder/subtractor.
module tb_calc_acc_ctrl;
  import calc_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       IN_VALID;
  logic       IN_READY;
  logic [1:0] IN_OP;
  logic [5:0] IN_DATA;
  logic [5:0] A_DATA;
  logic [5:0] B_DATA;
  logic       SUB_SEL;
  logic [5:0] ALU_RESULT;
  logic [5:0] ACC;
  logic       OUT_VALID;
  logic       OVF;
  logic       OVF_STICKY;

  int tests = 0;
  int fails = 0;

  calc_acc_ctrl #(.WIDTH(6)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_OP      (IN_OP),
    .IN_DATA    (IN_DATA),
    .A_DATA     (A_DATA),
    .B_DATA     (B_DATA),
    .SUB_SEL    (SUB_SEL),
    .ALU_RESULT (ALU_RESULT),
    .ACC        (ACC),
    .OUT_VALID  (OUT_VALID),
    .OVF        (OVF),
    .OVF_STICKY (OVF_STICKY)
  );

  // External adder/subtractor stage.
  assign ALU_RESULT = SUB_SEL ? (A_DATA - B_DATA) : (A_DATA + B_DATA);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] op;
    logic [5:0] data;
    logic [5:0] exp_a;
    logic [5:0] exp_b;
    logic       exp_sub;
    logic [5:0] exp_acc;
    logic       exp_ovf;
    logic       exp_sticky;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge CLK);
    chk("ready_before_accept", {7'd0, IN_READY}, 8'd1);
    IN_VALID = 1'b1;
    IN_OP    = v.op;
    IN_DATA  = v.data;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_OP    = OP_CLEAR;
    IN_DATA  = 6'h2A;
    chk("ready_issue", {7'd0, IN_READY}, 8'd0);
    chk("out_valid_issue", {7'd0, OUT_VALID}, 8'd0);
    chk("a_data", {2'd0, A_DATA}, {2'd0, v.exp_a});
    chk("b_data", {2'd0, B_DATA}, {2'd0, v.exp_b});
    chk("sub_sel", {7'd0, SUB_SEL}, {7'd0, v.exp_sub});
    @(posedge CLK);
    #1;
    chk("ready_wb", {7'd0, IN_READY}, 8'd0);
    chk("out_valid_wb", {7'd0, OUT_VALID}, 8'd0);
    @(posedge CLK);
    #1;
    chk("out_valid_pulse", {7'd0, OUT_VALID}, 8'd1);
    chk("acc", {2'd0, ACC}, {2'd0, v.exp_acc});
    chk("ovf", {7'd0, OVF}, {7'd0, v.exp_ovf});
    chk("ovf_sticky", {7'd0, OVF_STICKY}, {7'd0, v.exp_sticky});
    chk("ready_after_wb", {7'd0, IN_READY}, 8'd1);
  endtask

  initial begin
    logic [5:0] str_acc [4];
    int         pulses;

    //              op        data   a      b      sub   acc    ovf   sticky
    vecs[0]  = '{OP_LOAD,  6'd20, 6'h00, 6'd20, 1'b0, 6'd20, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD,   6'd15, 6'd20, 6'd15, 1'b0, 6'h23, 1'b1, 1'b1};
    vecs[2]  = '{OP_LOAD,  6'd5,  6'h23, 6'd5,  1'b0, 6'd5,  1'b0, 1'b1};
    vecs[3]  = '{OP_SUB,   6'd7,  6'd5,  6'd7,  1'b1, 6'h3E, 1'b0, 1'b1};
    vecs[4]  = '{OP_LOAD,  6'h20, 6'h3E, 6'h20, 1'b0, 6'h20, 1'b0, 1'b1};
    vecs[5]  = '{OP_SUB,   6'd1,  6'h20, 6'd1,  1'b1, 6'h1F, 1'b1, 1'b1};
    vecs[6]  = '{OP_ADD,   6'd1,  6'h1F, 6'd1,  1'b0, 6'h20, 1'b1, 1'b1};
    vecs[7]  = '{OP_CLEAR, 6'h15, 6'h20, 6'h15, 1'b0, 6'h00, 1'b0, 1'b0};
    vecs[8]  = '{OP_ADD,   6'h3F, 6'h00, 6'h3F, 1'b0, 6'h3F, 1'b0, 1'b0};
    vecs[9]  = '{OP_SUB,   6'h3F, 6'h3F, 6'h3F, 1'b1, 6'h00, 1'b0, 1'b0};
    // Runs after the streaming sequence leaves ACC at 22.
    vecs[10] = '{OP_ADD,   6'h0F, 6'h16, 6'h0F, 1'b0, 6'h25, 1'b1, 1'b1};

    // Accepted stream commands carry data 1, 4, 7, 10 onto ACC=0.
    str_acc[0] = 6'd1;
    str_acc[1] = 6'd5;
    str_acc[2] = 6'd12;
    str_acc[3] = 6'd22;

    RESET    = 1'b1;
    IN_VALID = 1'b0;
    IN_OP    = OP_LOAD;
    IN_DATA  = '0;
    #12;
    chk("rst_ready", {7'd0, IN_READY}, 8'd1);
    chk("rst_acc", {2'd0, ACC}, 8'd0);
    chk("rst_a", {2'd0, A_DATA}, 8'd0);
    chk("rst_b", {2'd0, B_DATA}, 8'd0);
    chk("rst_sub", {7'd0, SUB_SEL}, 8'd0);
    chk("rst_out_valid", {7'd0, OUT_VALID}, 8'd0);
    chk("rst_ovf", {7'd0, OVF}, 8'd0);
    chk("rst_sticky", {7'd0, OVF_STICKY}, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // IN_VALID held high with a new command every cycle; only every third
    // one lands on an IDLE edge, the rest must be dropped.
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      IN_OP    = OP_ADD;
      IN_DATA  = 6'(c + 1);
      chk("stream_ready", {7'd0, IN_READY}, {7'd0, (c % 3) == 0});
      @(posedge CLK);
      #1;
      chk("stream_out_valid", {7'd0, OUT_VALID}, {7'd0, (c % 3) == 2});
      if (OUT_VALID) pulses++;
      if ((c % 3) == 2) chk("stream_acc", {2'd0, ACC}, {2'd0, str_acc[c / 3]});
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("stream_pulses", 8'(pulses), 8'd4);

    run_vec(vecs[10]);

    // Reset lands between edges while ADD 3 is in ISSUE.
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_OP    = OP_ADD;
    IN_DATA  = 6'd3;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    chk("abort_in_issue", {7'd0, IN_READY}, 8'd0);
    #2;
    RESET = 1'b1;
    #1;
    chk("abort_acc", {2'd0, ACC}, 8'd0);
    chk("abort_a", {2'd0, A_DATA}, 8'd0);
    chk("abort_b", {2'd0, B_DATA}, 8'd0);
    chk("abort_ovf", {7'd0, OVF}, 8'd0);
    chk("abort_sticky", {7'd0, OVF_STICKY}, 8'd0);
    chk("abort_ready", {7'd0, IN_READY}, 8'd1);
    @(posedge CLK);
    #1;
    chk("abort_hold_acc", {2'd0, ACC}, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
      chk("post_abort_out_valid", {7'd0, OUT_VALID}, 8'd0);
      chk("post_abort_ready", {7'd0, IN_READY}, 8'd1);
      chk("post_abort_acc", {2'd0, ACC}, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
